// File: rtl/tlb_assoc_sv_pkg.sv
// Shared types for the fully associative TLB: permission bits, access and
// invalidation encodings, and the level-to-shift helper.
package tlb_assoc_sv_pkg;

  typedef struct packed {
    logic d;
    logic a;
    logic g;
    logic u;
    logic x;
    logic w;
    logic r;
  } tlb_perm_t;

  typedef enum logic [1:0] {
    ACC_LOAD  = 2'd0,
    ACC_STORE = 2'd1,
    ACC_EXEC  = 2'd2
  } tlb_acc_e;

  typedef enum logic [1:0] {
    INV_ALL      = 2'd0,
    INV_ASID     = 2'd1,
    INV_VPN      = 2'd2,
    INV_VPN_ASID = 2'd3
  } tlb_inv_e;

  // Number of low page-number bits supplied by the VA for a given page level.
  function automatic int unsigned level_shift(input logic [1:0] level,
                                              input int unsigned level_bits);
    return 32'(level) * level_bits;
  endfunction

endpackage

// File: rtl/tlb_perm_check.sv
// Combinational page-fault evaluation for a TLB hit: permission bits,
// privilege mode, SUM/MXR and superpage PPN alignment.
module tlb_perm_check
  import tlb_assoc_sv_pkg::*;
#(
  parameter int unsigned PPN_WIDTH  = 44,
  parameter int unsigned LEVEL_BITS = 9
) (
  input  tlb_perm_t            perm,
  input  logic [1:0]           acc,
  input  logic                 umode,
  input  logic                 sum,
  input  logic                 mxr,
  input  logic [1:0]           level,
  input  logic [PPN_WIDTH-1:0] ppn,
  output logic                 fault
);

  logic                 is_load;
  logic                 is_store;
  logic                 is_exec;
  logic [PPN_WIDTH-1:0] low_mask;
  logic                 misaligned;

  assign is_load    = (acc == ACC_LOAD);
  assign is_store   = (acc == ACC_STORE);
  assign is_exec    = (acc == ACC_EXEC);
  assign low_mask   = ~({PPN_WIDTH{1'b1}} << level_shift(level, LEVEL_BITS));
  assign misaligned = |(ppn & low_mask);

  always_comb begin
    fault = !perm.a;
    if (is_store && !perm.d) fault = 1'b1;
    if (is_load && !(perm.r || (perm.x && mxr))) fault = 1'b1;
    if (is_store && !perm.w) fault = 1'b1;
    if (is_exec && !perm.x) fault = 1'b1;
    if (umode && !perm.u) fault = 1'b1;
    // Supervisor may touch user pages only for data accesses with SUM set.
    if (!umode && perm.u && (is_exec || !sum)) fault = 1'b1;
    if (misaligned) fault = 1'b1;
  end

endmodule

// File: rtl/tlb_assoc_sv.sv
// Fully associative TLB with ASID/global matching, superpages, a one-cycle
// registered lookup, walker insert port and sfence.vma-style invalidation.
module tlb_assoc_sv
  import tlb_assoc_sv_pkg::*;
#(
  parameter int unsigned LEVELS     = 3,
  parameter int unsigned LEVEL_BITS = 9,
  parameter int unsigned VPN_WIDTH  = LEVELS * LEVEL_BITS,
  parameter int unsigned PPN_WIDTH  = 44,
  parameter int unsigned ASID_WIDTH = 16,
  parameter int unsigned ENTRIES    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [VPN_WIDTH-1:0]  req_vpn,
  input  logic [ASID_WIDTH-1:0] req_asid,
  input  logic [1:0]            req_acc,
  input  logic                  req_umode,
  input  logic                  req_sum,
  input  logic                  req_mxr,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic                  resp_fault,
  output logic [PPN_WIDTH-1:0]  resp_ppn,
  output logic [1:0]            resp_level,
  input  logic                  ins_valid,
  input  logic [VPN_WIDTH-1:0]  ins_vpn,
  input  logic [PPN_WIDTH-1:0]  ins_ppn,
  input  logic [ASID_WIDTH-1:0] ins_asid,
  input  logic [1:0]            ins_level,
  input  logic [6:0]            ins_perm,
  input  logic                  inv_valid,
  input  logic [1:0]            inv_mode,
  input  logic [ASID_WIDTH-1:0] inv_asid,
  input  logic [VPN_WIDTH-1:0]  inv_vpn
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic                  valid;
    logic [VPN_WIDTH-1:0]  vpn;
    logic [PPN_WIDTH-1:0]  ppn;
    logic [ASID_WIDTH-1:0] asid;
    logic [1:0]            level;
    tlb_perm_t             perm;
  } tlb_entry_t;

  function automatic logic [VPN_WIDTH-1:0] vpn_mask(input logic [1:0] level);
    return {VPN_WIDTH{1'b1}} << level_shift(level, LEVEL_BITS);
  endfunction

  function automatic logic inv_hit(input tlb_entry_t e, input logic [1:0] mode,
                                   input logic [ASID_WIDTH-1:0] asid,
                                   input logic [VPN_WIDTH-1:0] vpn);
    logic vpn_eq;
    logic asid_eq;
    vpn_eq  = (((e.vpn ^ vpn) & vpn_mask(e.level)) == '0);
    asid_eq = (e.asid == asid);
    unique case (tlb_inv_e'(mode))
      INV_ALL:      return 1'b1;
      INV_ASID:     return asid_eq && !e.perm.g;
      INV_VPN:      return vpn_eq;
      INV_VPN_ASID: return vpn_eq && asid_eq && !e.perm.g;
      default:      return 1'b0;
    endcase
  endfunction

  tlb_entry_t           entries_q [ENTRIES];
  tlb_entry_t           entries_d [ENTRIES];
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic                 lk_hit;
  logic [IDX_W-1:0]     lk_idx;
  tlb_entry_t           lk_e;
  logic [PPN_WIDTH-1:0] lk_mask, lk_ppn;
  logic                 lk_fault;
  logic                 ins_ok, ins_found;
  logic [IDX_W-1:0]     ins_idx;
  logic                 accept;

  assign req_ready = !inv_valid;
  assign accept    = req_valid && req_ready;

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (entries_q[i].valid &&
          (((entries_q[i].vpn ^ req_vpn) & vpn_mask(entries_q[i].level)) == '0) &&
          (entries_q[i].perm.g || entries_q[i].asid == req_asid)) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
    end
  end

  assign lk_e    = entries_q[lk_idx];
  assign lk_mask = {PPN_WIDTH{1'b1}} << level_shift(lk_e.level, LEVEL_BITS);
  assign lk_ppn  = (lk_e.ppn & lk_mask) | (PPN_WIDTH'(req_vpn) & ~lk_mask);

  tlb_perm_check #(
    .PPN_WIDTH  (PPN_WIDTH),
    .LEVEL_BITS (LEVEL_BITS)
  ) u_perm_check (
    .perm  (lk_e.perm),
    .acc   (req_acc),
    .umode (req_umode),
    .sum   (req_sum),
    .mxr   (req_mxr),
    .level (lk_e.level),
    .ppn   (lk_e.ppn),
    .fault (lk_fault)
  );

  // Invalidate first, then pick the insert victim from the surviving entries.
  always_comb begin
    entries_d = entries_q;
    rr_d      = rr_q;
    ins_found = 1'b0;
    ins_idx   = rr_q;
    ins_ok    = ins_valid && (32'(ins_level) < LEVELS);
    if (inv_valid) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        if (inv_hit(entries_q[i], inv_mode, inv_asid, inv_vpn)) entries_d[i].valid = 1'b0;
      end
    end
    if (ins_ok) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        if (!ins_found && entries_d[i].valid && entries_d[i].level == ins_level &&
            (((entries_d[i].vpn ^ ins_vpn) & vpn_mask(ins_level)) == '0) &&
            (entries_d[i].perm.g || entries_d[i].asid == ins_asid)) begin
          ins_found = 1'b1;
          ins_idx   = IDX_W'(i);
        end
      end
      for (int i = 0; i < int'(ENTRIES); i++) begin
        if (!ins_found && !entries_d[i].valid) begin
          ins_found = 1'b1;
          ins_idx   = IDX_W'(i);
        end
      end
      if (!ins_found) rr_d = rr_q + IDX_W'(1);
      entries_d[ins_idx] = '{valid: 1'b1, vpn: ins_vpn, ppn: ins_ppn, asid: ins_asid,
                             level: ins_level, perm: tlb_perm_t'(ins_perm)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) entries_q[i] <= '0;
      rr_q <= '0;
    end else begin
      entries_q <= entries_d;
      rr_q      <= rr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_fault <= 1'b0;
      resp_ppn   <= '0;
      resp_level <= '0;
    end else begin
      resp_valid <= accept;
      resp_hit   <= accept && lk_hit;
      resp_fault <= accept && lk_hit && lk_fault;
      resp_ppn   <= (accept && lk_hit) ? lk_ppn : '0;
      resp_level <= (accept && lk_hit) ? lk_e.level : 2'd0;
    end
  end

endmodule

// File: tb/tb_tlb_assoc_sv.sv
// Self-checking bench for tlb_assoc_sv: table of lookups plus hand-written
// sequences for invalidation, replacement, simultaneous events and reset.
module tb_tlb_assoc_sv;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [26:0] req_vpn;
  logic [15:0] req_asid;
  logic [1:0]  req_acc;
  logic        req_umode, req_sum, req_mxr;
  logic        resp_valid, resp_hit, resp_fault;
  logic [43:0] resp_ppn;
  logic [1:0]  resp_level;
  logic        ins_valid;
  logic [26:0] ins_vpn;
  logic [43:0] ins_ppn;
  logic [15:0] ins_asid;
  logic [1:0]  ins_level;
  logic [6:0]  ins_perm;
  logic        inv_valid;
  logic [1:0]  inv_mode;
  logic [15:0] inv_asid;
  logic [26:0] inv_vpn;

  always #5 clk = ~clk;

  tlb_assoc_sv dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_vpn    (req_vpn),
    .req_asid   (req_asid),
    .req_acc    (req_acc),
    .req_umode  (req_umode),
    .req_sum    (req_sum),
    .req_mxr    (req_mxr),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .resp_fault (resp_fault),
    .resp_ppn   (resp_ppn),
    .resp_level (resp_level),
    .ins_valid  (ins_valid),
    .ins_vpn    (ins_vpn),
    .ins_ppn    (ins_ppn),
    .ins_asid   (ins_asid),
    .ins_level  (ins_level),
    .ins_perm   (ins_perm),
    .inv_valid  (inv_valid),
    .inv_mode   (inv_mode),
    .inv_asid   (inv_asid),
    .inv_vpn    (inv_vpn)
  );

  // mode = {umode, sum, mxr}; hf = {hit, fault}
  typedef struct packed {
    logic [26:0] vpn;
    logic [15:0] asid;
    logic [1:0]  acc;
    logic [2:0]  mode;
    logic [1:0]  hf;
    logic [43:0] ppn;
    logic [1:0]  lvl;
  } vec_t;

  typedef struct packed {
    logic [15:0] id;
    logic [1:0]  hf;
    logic [43:0] ppn;
    logic [1:0]  lvl;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic [26:0] vpn, input logic [15:0] asid,
                              input logic [1:0] acc, input logic [2:0] mode,
                              input logic [1:0] hf, input logic [43:0] ppn,
                              input logic [1:0] lvl);
    return '{vpn, asid, acc, mode, hf, ppn, lvl};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Scoreboard: every accepted lookup must answer at the very next negedge.
  exp_t e;
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (!(resp_valid === 1'b1 && {resp_hit, resp_fault} === e.hf &&
              resp_ppn === e.ppn && resp_level === e.lvl)) begin
          errors++;
          $display("FAIL lookup_%0d: got v=%b hit/fault=%b%b ppn=%h lvl=%0d, expected v=1 hit/fault=%b ppn=%h lvl=%0d",
                   e.id, resp_valid, resp_hit, resp_fault, resp_ppn, resp_level,
                   e.hf, e.ppn, e.lvl);
        end
      end else begin
        checks++;
        if ({resp_valid, resp_hit, resp_fault, resp_ppn, resp_level} !== '0) begin
          errors++;
          $display("FAIL idle_resp: got v=%b hit=%b fault=%b ppn=%h lvl=%0d, expected all zero",
                   resp_valid, resp_hit, resp_fault, resp_ppn, resp_level);
        end
      end
    end
  end

  task automatic lookup(input vec_t v, input int id);
    req_valid = 1'b1;
    req_vpn   = v.vpn;
    req_asid  = v.asid;
    req_acc   = v.acc;
    {req_umode, req_sum, req_mxr} = v.mode;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    exp_q.push_back('{16'(id), v.hf, v.ppn, v.lvl});
  endtask

  task automatic insert(input logic [26:0] vpn, input logic [43:0] ppn,
                        input logic [15:0] asid, input logic [1:0] lvl,
                        input logic [6:0] perm);
    ins_valid = 1'b1;
    ins_vpn   = vpn;
    ins_ppn   = ppn;
    ins_asid  = asid;
    ins_level = lvl;
    ins_perm  = perm;
    @(posedge clk);
    #1;
    ins_valid = 1'b0;
  endtask

  task automatic inv(input logic [1:0] mode, input logic [15:0] asid, input logic [26:0] vpn);
    inv_valid = 1'b1;
    inv_mode  = mode;
    inv_asid  = asid;
    inv_vpn   = vpn;
    #1;
    chk("req_ready_during_inv", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    inv_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_vpn = '0; req_asid = '0; req_acc = '0;
    req_umode = 1'b0; req_sum = 1'b0; req_mxr = 1'b0;
    ins_valid = 1'b0; ins_vpn = '0; ins_ppn = '0; ins_asid = '0; ins_level = '0; ins_perm = '0;
    inv_valid = 1'b0; inv_mode = '0; inv_asid = '0; inv_vpn = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_resp", 64'({resp_valid, resp_hit, resp_fault, resp_level}), 64'd0);
    chk("reset_resp_ppn", 64'(resp_ppn), 64'd0);

    insert(27'h12345, 44'hABCDE, 16'd5, 2'd0, 7'h21);  // E0 A|R
    insert(27'h00100, 44'h200,   16'd5, 2'd0, 7'h2C);  // E1 A|U|X
    insert(27'h00200, 44'h300,   16'd7, 2'd0, 7'h63);  // E2 D|A|W|R
    insert(27'h00201, 44'h301,   16'd7, 2'd0, 7'h23);  // E3 A|W|R
    insert(27'h00202, 44'h302,   16'd7, 2'd0, 7'h01);  // E4 R, A clear
    insert(27'h00400, 44'h1000,  16'd5, 2'd1, 7'h21);  // E5 2 MiB
    insert(27'h00800, 44'h1001,  16'd5, 2'd1, 7'h21);  // E6 misaligned 2 MiB
    insert(27'h00401, 44'h999,   16'd5, 2'd0, 7'h21);  // E7 shadowed by E5
    insert(27'h03333, 44'h555,   16'd5, 2'd3, 7'h21);  // illegal level, dropped

    tbl.push_back(mk(27'h12345, 16'd5, 2'd0, 3'b000, 2'b10, 44'hABCDE, 2'd0));
    tbl.push_back(mk(27'h12345, 16'd5, 2'd1, 3'b000, 2'b11, 44'hABCDE, 2'd0));
    tbl.push_back(mk(27'h12345, 16'd5, 2'd2, 3'b000, 2'b11, 44'hABCDE, 2'd0));
    tbl.push_back(mk(27'h12345, 16'd5, 2'd0, 3'b100, 2'b11, 44'hABCDE, 2'd0));
    tbl.push_back(mk(27'h12345, 16'd6, 2'd0, 3'b000, 2'b00, 44'h0,     2'd0));
    tbl.push_back(mk(27'h12346, 16'd5, 2'd0, 3'b000, 2'b00, 44'h0,     2'd0));
    tbl.push_back(mk(27'h00100, 16'd5, 2'd0, 3'b100, 2'b11, 44'h200,   2'd0));
    tbl.push_back(mk(27'h00100, 16'd5, 2'd0, 3'b101, 2'b10, 44'h200,   2'd0));
    tbl.push_back(mk(27'h00100, 16'd5, 2'd2, 3'b100, 2'b10, 44'h200,   2'd0));
    tbl.push_back(mk(27'h00100, 16'd5, 2'd2, 3'b010, 2'b11, 44'h200,   2'd0));
    tbl.push_back(mk(27'h00100, 16'd5, 2'd0, 3'b011, 2'b10, 44'h200,   2'd0));
    tbl.push_back(mk(27'h00100, 16'd5, 2'd0, 3'b001, 2'b11, 44'h200,   2'd0));
    tbl.push_back(mk(27'h00200, 16'd7, 2'd1, 3'b000, 2'b10, 44'h300,   2'd0));
    tbl.push_back(mk(27'h00201, 16'd7, 2'd1, 3'b000, 2'b11, 44'h301,   2'd0));
    tbl.push_back(mk(27'h00201, 16'd7, 2'd0, 3'b000, 2'b10, 44'h301,   2'd0));
    tbl.push_back(mk(27'h00202, 16'd7, 2'd0, 3'b000, 2'b11, 44'h302,   2'd0));
    tbl.push_back(mk(27'h005AB, 16'd5, 2'd0, 3'b000, 2'b10, 44'h11AB,  2'd1));
    tbl.push_back(mk(27'h00805, 16'd5, 2'd0, 3'b000, 2'b11, 44'h1005,  2'd1));
    tbl.push_back(mk(27'h00401, 16'd5, 2'd0, 3'b000, 2'b10, 44'h1001,  2'd1));
    tbl.push_back(mk(27'h00600, 16'd5, 2'd0, 3'b000, 2'b00, 44'h0,     2'd0));
    tbl.push_back(mk(27'h005AB, 16'd9, 2'd0, 3'b000, 2'b00, 44'h0,     2'd0));
    tbl.push_back(mk(27'h03333, 16'd5, 2'd0, 3'b000, 2'b00, 44'h0,     2'd0));
    for (int i = 0; i < tbl.size(); i++) lookup(tbl[i], i);

    // Global reinsert overwrites E0 and makes it visible to other ASIDs.
    insert(27'h12345, 44'hABCDE, 16'd5, 2'd0, 7'h31);
    lookup(mk(27'h12345, 16'd6, 2'd0, 3'b000, 2'b10, 44'hABCDE, 2'd0), 100);

    inv(2'd1, 16'd5, 27'h0);
    lookup(mk(27'h12345, 16'd5, 2'd0, 3'b000, 2'b10, 44'hABCDE, 2'd0), 101);
    lookup(mk(27'h00100, 16'd5, 2'd0, 3'b101, 2'b00, 44'h0,     2'd0), 102);
    lookup(mk(27'h005AB, 16'd5, 2'd0, 3'b000, 2'b00, 44'h0,     2'd0), 103);
    lookup(mk(27'h00200, 16'd7, 2'd1, 3'b000, 2'b10, 44'h300,   2'd0), 104);
    inv(2'd2, 16'd0, 27'h12345);
    lookup(mk(27'h12345, 16'd6, 2'd0, 3'b000, 2'b00, 44'h0,     2'd0), 105);
    inv(2'd3, 16'd7, 27'h00200);
    lookup(mk(27'h00200, 16'd7, 2'd0, 3'b000, 2'b00, 44'h0,     2'd0), 106);
    lookup(mk(27'h00201, 16'd7, 2'd0, 3'b000, 2'b10, 44'h301,   2'd0), 107);

    // Fill past capacity: first three get round-robin victims 0,1,2.
    inv(2'd0, 16'd0, 27'h0);
    for (int i = 0; i < 35; i++) insert(27'h1000 + 27'(i), 44'h2000 + 44'(i), 16'd1, 2'd0, 7'h21);
    for (int i = 0; i < 3; i++)
      lookup(mk(27'h1000 + 27'(i), 16'd1, 2'd0, 3'b000, 2'b00, 44'h0, 2'd0), 110 + i);
    lookup(mk(27'h1003, 16'd1, 2'd0, 3'b000, 2'b10, 44'h2003, 2'd0), 113);
    lookup(mk(27'h1022, 16'd1, 2'd0, 3'b000, 2'b10, 44'h2022, 2'd0), 114);
    insert(27'h1100, 44'h2100, 16'd1, 2'd0, 7'h21);  // rr_ptr 3 evicts 0x1003
    lookup(mk(27'h1003, 16'd1, 2'd0, 3'b000, 2'b00, 44'h0,    2'd0), 115);
    lookup(mk(27'h1100, 16'd1, 2'd0, 3'b000, 2'b10, 44'h2100, 2'd0), 116);
    lookup(mk(27'h1004, 16'd1, 2'd0, 3'b000, 2'b10, 44'h2004, 2'd0), 117);

    // Invalidate-all with a same-cycle insert and a stalled lookup request.
    ins_valid = 1'b1; ins_vpn = 27'h7; ins_ppn = 44'h77; ins_asid = 16'd1;
    ins_level = 2'd0; ins_perm = 7'h21;
    req_valid = 1'b1; req_vpn = 27'h7; req_asid = 16'd1; req_acc = 2'd0;
    inv(2'd0, 16'd0, 27'h0);
    ins_valid = 1'b0;
    req_valid = 1'b0;
    lookup(mk(27'h7,    16'd1, 2'd0, 3'b000, 2'b10, 44'h77, 2'd0), 120);
    lookup(mk(27'h1004, 16'd1, 2'd0, 3'b000, 2'b00, 44'h0,  2'd0), 121);
    lookup(mk(27'h1100, 16'd1, 2'd0, 3'b000, 2'b00, 44'h0,  2'd0), 122);
    repeat (2) @(posedge clk);
    #1;

    // Reset right after acceptance must squash the pending response.
    req_valid = 1'b1; req_vpn = 27'h7; req_asid = 16'd1; req_acc = 2'd0;
    {req_umode, req_sum, req_mxr} = 3'b000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_lookup_valid", 64'(resp_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_valid", 64'({resp_valid, resp_hit, resp_ppn}), 64'd0);
    rst = 1'b0;
    chk("post_rst_ready", 64'(req_ready), 64'd1);
    lookup(mk(27'h7, 16'd1, 2'd0, 3'b000, 2'b00, 44'h0, 2'd0), 130);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
